// File: rtl/tail_light_pkg.sv
// Shared types and lamp patterns for the tail light sequencer.
package tail_light_pkg;

   typedef enum logic [3:0] {
      IDLE    = 4'd0,
      L1      = 4'd1,
      L2      = 4'd2,
      L3      = 4'd3,
      R1      = 4'd4,
      R2      = 4'd5,
      R3      = 4'd6,
      HAZ_ON  = 4'd7,
      SEQ_OFF = 4'd8
   } state_t;

   typedef enum logic [1:0] {
      REQ_NONE,
      REQ_LEFT,
      REQ_RIGHT,
      REQ_HAZ
   } req_t;

   localparam logic [2:0] PAT_L1 = 3'b001;
   localparam logic [2:0] PAT_L2 = 3'b011;
   localparam logic [2:0] PAT_L3 = 3'b111;
   localparam logic [2:0] PAT_R1 = 3'b100;
   localparam logic [2:0] PAT_R2 = 3'b110;
   localparam logic [2:0] PAT_R3 = 3'b111;

   // both turn levels together mean hazard
   function automatic req_t get_req(input logic left,
                                    input logic right,
                                    input logic hazard);
      req_t r;
      if (hazard || (left && right)) r = REQ_HAZ;
      else if (left)                 r = REQ_LEFT;
      else if (right)                r = REQ_RIGHT;
      else                           r = REQ_NONE;
      return r;
   endfunction

endpackage

// File: rtl/tail_light_sequencer_timer.sv
// Step timer: counts 0..STEP_DIV-1 and flags the last count.
module tail_step_timer
   import tail_light_pkg::*;
#(
   parameter int STEP_DIV = 12_500_000
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   output logic step
);

   localparam int CW = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(STEP_DIV - 1);

   logic [CW-1:0] cnt;

   assign step = (cnt == LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         cnt <= '0;
      else if (clear || step)
         cnt <= '0;
      else
         cnt <= cnt + CW'(1);
   end

endmodule

// File: rtl/tail_light_sequencer.sv
// Tail light sequencer: turn/hazard sweep FSM with brake overlay.
module tail_light_sequencer
   import tail_light_pkg::*;
#(
   parameter int STEP_DIV = 12_500_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       left,
   input  logic       right,
   input  logic       hazard,
   input  logic       brake,
   output logic [2:0] Lcba,
   output logic [2:0] Rabc,
   output logic       seq_active
);

   state_t     state, nxt;
   req_t       req;
   logic       step;
   logic [2:0] l_d, r_d;

   assign req = get_req(left, right, hazard);

   tail_step_timer #(.STEP_DIV(STEP_DIV)) u_timer (
      .clk   (clk),
      .reset (reset),
      .clear (state == IDLE),
      .step  (step)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= IDLE;
      else
         state <= nxt;
   end

   always_comb begin
      nxt = state;
      unique case (state)
         IDLE, SEQ_OFF: begin
            if (state == IDLE || step) begin
               unique case (req)
                  REQ_HAZ:   nxt = HAZ_ON;
                  REQ_LEFT:  nxt = L1;
                  REQ_RIGHT: nxt = R1;
                  default:   nxt = IDLE;
               endcase
            end
         end
         L1: if (step) nxt = (req == REQ_LEFT) ? L2 : SEQ_OFF;
         L2: if (step) nxt = (req == REQ_LEFT) ? L3 : SEQ_OFF;
         R1: if (step) nxt = (req == REQ_RIGHT) ? R2 : SEQ_OFF;
         R2: if (step) nxt = (req == REQ_RIGHT) ? R3 : SEQ_OFF;
         L3, R3, HAZ_ON: if (step) nxt = SEQ_OFF;
         default: nxt = IDLE;
      endcase
   end

   // lamps are derived from the state being entered, so they move with it
   always_comb begin
      l_d = '0;
      r_d = '0;
      unique case (nxt)
         L1:      l_d = PAT_L1;
         L2:      l_d = PAT_L2;
         L3:      l_d = PAT_L3;
         R1:      r_d = PAT_R1;
         R2:      r_d = PAT_R2;
         R3:      r_d = PAT_R3;
         HAZ_ON:  begin l_d = '1; r_d = '1; end
         default: ;
      endcase
      if (brake) begin
         unique case (nxt)
            IDLE, SEQ_OFF: begin l_d = '1; r_d = '1; end
            L1, L2, L3:    r_d = '1;
            R1, R2, R3:    l_d = '1;
            default:       ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         Lcba       <= '0;
         Rabc       <= '0;
         seq_active <= 1'b0;
      end else begin
         Lcba       <= l_d;
         Rabc       <= r_d;
         seq_active <= (nxt != IDLE);
      end
   end

endmodule

// File: tb/tb_tail_light_sequencer.sv
// Randomized and directed bench for tail_light_sequencer (STEP_DIV=4).
module tb_tail_light_sequencer;

   localparam int D = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic       left, right, hazard, brake;
   logic [2:0] Lcba, Rabc;
   logic       seq_active;

   int nchk = 0;
   int nerr = 0;

   tail_light_sequencer #(.STEP_DIV(D)) dut (
      .clk        (clk),
      .reset      (reset),
      .left       (left),
      .right      (right),
      .hazard     (hazard),
      .brake      (brake),
      .Lcba       (Lcba),
      .Rabc       (Rabc),
      .seq_active (seq_active)
   );

   always #5 clk = ~clk;

   // model: mode 0 none, 1 left, 2 right, 3 hazard; n = lamps lit (0 = dark step)
   int         m_act  = 0;
   int         m_mode = 0;
   int         m_n    = 0;
   int         m_t    = 0;
   logic [2:0] m_l    = '0;
   logic [2:0] m_r    = '0;
   logic       m_sa   = 1'b0;

   function automatic int req_of(input logic l, input logic r,
                                 input logic h);
      if (h || (l && r)) return 3;
      if (l) return 1;
      if (r) return 2;
      return 0;
   endfunction

   task automatic start_seq(input int q);
      m_act  = 1;
      m_mode = q;
      m_n    = (q == 3) ? 3 : 1;
      m_t    = 0;
   endtask

   always @(posedge clk or posedge reset) begin : model
      int q;
      bit stp;
      bit lit;
      if (reset) begin
         m_act = 0; m_mode = 0; m_n = 0; m_t = 0;
         m_l = '0; m_r = '0; m_sa = 1'b0;
      end else begin
         q = req_of(left, right, hazard);
         if (m_act == 0) begin
            if (q != 0) start_seq(q);
         end else begin
            stp = (m_t == D - 1);
            m_t = (m_t + 1) % D;
            if (stp) begin
               if (m_n == 0) begin
                  if (q == 0) m_act = 0;
                  else        start_seq(q);
               end else if (m_mode == 3 || q != m_mode || m_n == 3)
                  m_n = 0;
               else
                  m_n = m_n + 1;
            end
         end
         lit = (m_act != 0) && (m_n != 0);
         m_l = '0;
         m_r = '0;
         if (lit) begin
            if (m_mode == 1) m_l = 3'((1 << m_n) - 1);
            if (m_mode == 2) m_r = 3'((7 << (3 - m_n)) & 7);
            if (m_mode == 3) begin m_l = 3'd7; m_r = 3'd7; end
         end
         if (brake) begin
            if (!lit) begin m_l = 3'd7; m_r = 3'd7; end
            else if (m_mode == 1) m_r = 3'd7;
            else if (m_mode == 2) m_l = 3'd7;
         end
         m_sa = (m_act != 0);
      end
   end

   always @(negedge clk) begin
      nchk++;
      if ({Lcba, Rabc, seq_active} !== {m_l, m_r, m_sa}) begin
         nerr++;
         $display("FAIL model t=%0t got L=%b R=%b a=%b want L=%b R=%b a=%b",
                  $time, Lcba, Rabc, seq_active, m_l, m_r, m_sa);
      end
   end

   task automatic chk(input string nm, input logic [6:0] exp);
      nchk++;
      if ({Lcba, Rabc, seq_active} !== exp) begin
         nerr++;
         $display("FAIL %s t=%0t got L=%b R=%b a=%b want L=%b R=%b a=%b",
                  nm, $time, Lcba, Rabc, seq_active,
                  exp[6:4], exp[3:1], exp[0]);
      end
   endtask

   initial begin
      reset = 1'b1;
      left = 0; right = 0; hazard = 0; brake = 0;
      repeat (2) @(negedge clk);
      chk("reset_state", 7'b000_000_0);
      reset = 1'b0;
      @(negedge clk);
      chk("idle", 7'b000_000_0);

      // left held from idle, then dropped in L2
      left = 1;
      for (int c = 1; c <= 29; c++) begin
         @(negedge clk);
         case (c)
            1:  chk("left_c1",  7'b001_000_1);
            5:  chk("left_c5",  7'b011_000_1);
            9:  chk("left_c9",  7'b111_000_1);
            13: chk("left_c13", 7'b000_000_1);
            17: chk("left_c17", 7'b001_000_1);
            21: chk("left_c21", 7'b011_000_1);
            25: chk("left_off", 7'b000_000_1);
            29: chk("left_idle", 7'b000_000_0);
            default: ;
         endcase
         if (c == 22) left = 0;
      end

      // right with brake
      right = 1; brake = 1;
      for (int c = 1; c <= 18; c++) begin
         @(negedge clk);
         case (c)
            1:  chk("rbrk_c1",  7'b111_100_1);
            5:  chk("rbrk_c5",  7'b111_110_1);
            9:  chk("rbrk_c9",  7'b111_111_1);
            11: chk("rbrk_lag", 7'b000_111_1);
            18: chk("rbrk_idle", 7'b000_000_0);
            default: ;
         endcase
         if (c == 10) brake = 0;
         if (c == 11) right = 0;
      end

      // left+right acts as hazard; brake ignored while lamps on
      left = 1; right = 1;
      for (int c = 1; c <= 18; c++) begin
         @(negedge clk);
         case (c)
            1:  chk("haz_c1",  7'b111_111_1);
            3:  chk("haz_brk", 7'b111_111_1);
            5:  chk("haz_c5",  7'b000_000_1);
            9:  chk("haz_c9",  7'b111_111_1);
            18: chk("haz_idle", 7'b000_000_0);
            default: ;
         endcase
         if (c == 2) brake = 1;
         if (c == 3) brake = 0;
         if (c == 10) begin left = 0; right = 0; end
      end

      // asynchronous reset in R2
      right = 1;
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         if (c == 1) chk("rst_r1", 7'b000_100_1);
         if (c == 6) chk("rst_r2", 7'b000_110_1);
      end
      #1 reset = 1'b1;
      #1 chk("rst_async", 7'b000_000_0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("rst_release", 7'b000_100_1);
      right = 0;
      repeat (12) @(negedge clk);

      // randomized traffic with occasional mid-cycle resets
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         if ($urandom_range(5) == 0) begin
            left   = 1'($urandom_range(1));
            right  = 1'($urandom_range(1));
            hazard = ($urandom_range(9) < 2);
         end
         if ($urandom_range(9) == 0) brake = ~brake;
         if ($urandom_range(499) == 0) begin
            #1 reset = 1'b1;
            #2 reset = 1'b0;
         end
      end

      @(negedge clk);
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
